// File: rtl/stanh_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stanh_seq : sequencer for one stochastic tanh evaluation, counts sc_y ones |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module stanh_seq #(
   parameter int N    = 10,
   parameter int WARM = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [N-1:0] x_in,
   output logic [N-1:0] sc_x,
   output logic         sc_clr,
   input  logic         sc_y,
   output logic [N-1:0] result,
   output logic         result_valid,
   input  logic         result_ready,
   output logic         busy
);

   localparam int c_tw = ((N + 1) > $clog2(WARM + 1)) ? (N + 1) : $clog2(WARM + 1);
   localparam logic [c_tw-1:0] c_len     = c_tw'(2 ** N);
   localparam logic [c_tw-1:0] c_warm_ld = (WARM > 0) ? c_tw'(WARM - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_WARM  = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [c_tw-1:0] r_timer;
   logic [N:0]      r_cnt;
   logic [N:0]      w_sum;
   logic [N-1:0]    r_sc_x;
   logic [N-1:0]    r_result;
   logic            r_valid;
   logic            r_y;
   logic            r_take;

   // sc_y is captured in a flop first; r_take marks which captures belong to RUN
   assign w_sum = r_cnt + {{N{1'b0}}, (r_take & r_y)};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start_valid) w_next = S_CLEAR;
         S_CLEAR: w_next = (WARM == 0) ? S_RUN : S_WARM;
         S_WARM:  if (r_timer == '0) w_next = S_RUN;
         S_RUN:   if (r_timer == '0) w_next = S_DONE;
         S_DONE:  if (result_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timer  <= '0;
         r_cnt    <= '0;
         r_sc_x   <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_y      <= 1'b0;
         r_take   <= 1'b0;
      end else begin
         r_y    <= sc_y;
         r_take <= (r_state == S_RUN) && (r_timer != '0);
         case (r_state)
            S_IDLE: begin
               if (start_valid) begin
                  r_sc_x <= x_in;
                  r_cnt  <= '0;
               end
            end
            S_CLEAR: begin
               r_timer <= (WARM == 0) ? c_len : c_warm_ld;
            end
            S_WARM: begin
               if (r_timer == '0) r_timer <= c_len;
               else               r_timer <= r_timer - c_tw'(1);
            end
            S_RUN: begin
               // timer runs LEN..0: LEN sampling cycles plus one drain edge for the last capture
               if (r_take) r_cnt <= w_sum;
               if (r_timer == '0) begin
                  r_result <= w_sum[N] ? {N{1'b1}} : w_sum[N-1:0];
                  r_valid  <= 1'b1;
               end else begin
                  r_timer <= r_timer - c_tw'(1);
               end
            end
            S_DONE: begin
               if (result_ready) r_valid <= 1'b0;
            end
            default: begin
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign start_ready  = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);
   assign sc_clr       = (r_state == S_CLEAR);
   assign sc_x         = r_sc_x;
   assign result       = r_result;
   assign result_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_stanh_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stanh_seq : self-checking bench, WARM=16 and WARM=0 instances          |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_stanh_seq;
   localparam int N   = 10;
   localparam int LEN = 1 << N;

   logic         clk = 1'b0;
   logic         rst          [2];
   logic         start_valid  [2];
   logic         start_ready  [2];
   logic [N-1:0] x_in         [2];
   logic [N-1:0] sc_x         [2];
   logic         sc_clr       [2];
   logic         sc_y         [2];
   logic [N-1:0] result       [2];
   logic         result_valid [2];
   logic         result_ready [2];
   logic         busy         [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   stanh_seq #(.N(N), .WARM(16)) u_dut_w16 (
      .clk(clk), .rst(rst[0]), .start_valid(start_valid[0]), .start_ready(start_ready[0]),
      .x_in(x_in[0]), .sc_x(sc_x[0]), .sc_clr(sc_clr[0]), .sc_y(sc_y[0]),
      .result(result[0]), .result_valid(result_valid[0]), .result_ready(result_ready[0]),
      .busy(busy[0]));

   stanh_seq #(.N(N), .WARM(0)) u_dut_w0 (
      .clk(clk), .rst(rst[1]), .start_valid(start_valid[1]), .start_ready(start_ready[1]),
      .x_in(x_in[1]), .sc_x(sc_x[1]), .sc_clr(sc_clr[1]), .sc_y(sc_y[1]),
      .result(result[1]), .result_valid(result_valid[1]), .result_ready(result_ready[1]),
      .busy(busy[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input int d);
      chk("rst_start_ready", 32'(start_ready[d]), 32'd1);
      chk("rst_busy",        32'(busy[d]),        32'd0);
      chk("rst_sc_x",        32'(sc_x[d]),        32'd0);
      chk("rst_sc_clr",      32'(sc_clr[d]),      32'd0);
      chk("rst_result",      32'(result[d]),      32'd0);
      chk("rst_valid",       32'(result_valid[d]), 32'd0);
   endtask

   // One request on DUT d. Must be called just after a rising edge (+1).
   // mode: 0 random, 1 alternating from 1, 2 all ones, 3 all zeros, 4 ones for first 100.
   // abort_at >= 0 asserts reset during that RUN cycle and abandons the request.
   task automatic txn(input int d, input logic [N-1:0] x, input int mode,
                      input int hold, input int abort_at);
      int warm;
      int lat;
      int sum;
      int expv;
      int clr_seen;
      int early;
      int bad;
      bit pat [LEN];
      warm = (d == 0) ? 16 : 0;
      lat  = 2 + warm + LEN;
      sum  = 0;
      for (int k = 0; k < LEN; k++) begin
         case (mode)
            1:       pat[k] = ((k % 2) == 0);
            2:       pat[k] = 1'b1;
            3:       pat[k] = 1'b0;
            4:       pat[k] = (k < 100);
            default: pat[k] = 1'($urandom);
         endcase
         sum += int'(pat[k]);
      end
      expv     = (sum > LEN - 1) ? LEN - 1 : sum;
      clr_seen = 0;
      early    = 0;

      chk("pre_start_ready", 32'(start_ready[d]), 32'd1);
      start_valid[d]  = 1'b1;
      x_in[d]         = x;
      result_ready[d] = 1'b0;
      @(posedge clk); #1;
      start_valid[d] = 1'b0;
      x_in[d]        = N'($urandom);
      chk("acc_sc_x",        32'(sc_x[d]),        32'(x));
      chk("acc_busy",        32'(busy[d]),        32'd1);
      chk("acc_start_ready", 32'(start_ready[d]), 32'd0);

      for (int p = 0; p < lat; p++) begin
         int k;
         k = p - 1 - warm;
         if (sc_clr[d]) clr_seen++;
         if (result_valid[d]) early++;
         if (abort_at >= 0 && k == abort_at) begin
            rst[d] = 1'b0;
            #1;
            chk_reset(d);
            bad = 0;
            repeat (3) begin
               @(posedge clk); #1;
               if (result_valid[d] || busy[d]) bad++;
            end
            chk("abort_quiet", 32'(bad), 32'd0);
            rst[d]  = 1'b1;
            sc_y[d] = 1'b0;
            return;
         end
         sc_y[d] = (k >= 0 && k < LEN) ? pat[k] : 1'($urandom);
         @(posedge clk); #1;
      end

      chk("clr_pulses",   32'(clr_seen),        32'd1);
      chk("early_valid",  32'(early),           32'd0);
      chk("lat_valid",    32'(result_valid[d]), 32'd1);
      chk("result",       32'(result[d]),       32'(expv));
      chk("done_ready",   32'(start_ready[d]),  32'd0);

      start_valid[d] = 1'b1;
      x_in[d]        = ~x;
      bad            = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (result[d] !== N'(expv) || !result_valid[d] || start_ready[d] || sc_x[d] !== x) bad++;
      end
      chk("hold_stable", 32'(bad), 32'd0);

      result_ready[d] = 1'b1;
      @(posedge clk); #1;
      start_valid[d]  = 1'b0;
      result_ready[d] = 1'b0;
      chk("hs_valid_drop", 32'(result_valid[d]), 32'd0);
      chk("hs_idle",       32'(start_ready[d]),  32'd1);
      chk("hs_busy",       32'(busy[d]),         32'd0);
      chk("hs_result",     32'(result[d]),       32'(expv));
      chk("hs_sc_x",       32'(sc_x[d]),         32'(x));
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d]          = 1'b0;
         start_valid[d]  = 1'b0;
         x_in[d]         = '0;
         sc_y[d]         = 1'b0;
         result_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) chk_reset(d);
      rst[0] = 1'b1;
      rst[1] = 1'b1;

      txn(0, 10'h200, 1, 0, -1);
      txn(0, 10'h3a7, 2, 50, -1);
      txn(0, 10'h001, 3, 3, -1);
      txn(0, N'($urandom), 0, 2, -1);
      txn(0, N'($urandom), 0, 300, 300);
      txn(0, N'($urandom), 0, 1, -1);
      txn(1, 10'h155, 4, 0, -1);
      txn(1, N'($urandom), 0, 5, -1);
      txn(1, N'($urandom), 2, 0, 17);
      txn(1, N'($urandom), 1, 0, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
